// File: rtl/quidditch_match_controller.sv
// -----------------------------------------------------------------------------
// quidditch_match_controller
//
// Match-level sequencer for the ball/bludger controllers. It keeps both team
// scores, holds the balls centred for a serve pause after the start and after
// every goal, and declares a winner once a team reaches WIN_SCORE.
//
// Parameters:
//   WIN_SCORE    score that ends the match (1 .. 2^SCORE_WIDTH-1)
//   SCORE_WIDTH  width of each score counter
//   SERVE_DELAY  cycles game_initiated stays low per serve pause (>= 1)
//
// Ports:
//   clk             system clock
//   rst             synchronous, active-high reset
//   start_btn       start/restart request, rising edge acts
//   blue_score_up   blue goal indication, rising edge = one goal
//   red_score_up    red goal indication, rising edge = one goal
//   game_initiated  high only while play is running
//   game_over       high only once the match has been decided
//   blue_score      blue team score
//   red_score       red team score
//   winner          00 none, 01 blue, 10 red, 11 draw
// -----------------------------------------------------------------------------
module quidditch_match_controller #(
    parameter int WIN_SCORE   = 5,
    parameter int SCORE_WIDTH = 4,
    parameter int SERVE_DELAY = 50_000_000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_btn,
    input  logic                   blue_score_up,
    input  logic                   red_score_up,
    output logic                   game_initiated,
    output logic                   game_over,
    output logic [SCORE_WIDTH-1:0] blue_score,
    output logic [SCORE_WIDTH-1:0] red_score,
    output logic [1:0]             winner
);

    // SERVE_DELAY-1 is the largest value the serve counter ever holds.
    localparam int CNT_W = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
    localparam logic [CNT_W-1:0]       SERVE_LOAD = CNT_W'(SERVE_DELAY - 1);
    localparam logic [SCORE_WIDTH-1:0] WIN_V      = SCORE_WIDTH'(WIN_SCORE);

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_BLUE = 2'b01;
    localparam logic [1:0] WIN_RED  = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_PLAY  = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SCORE_WIDTH-1:0] blue_q, blue_d;
    logic [SCORE_WIDTH-1:0] red_q, red_d;
    logic [1:0]             winner_q, winner_d;

    // Previous-value registers reset to 1 so a level held high through reset
    // never looks like a fresh edge.
    logic start_prev_q, blue_prev_q, red_prev_q;
    logic start_edge, blue_edge, red_edge;

    logic [SCORE_WIDTH-1:0] blue_inc, red_inc;
    logic                   blue_wins, red_wins;

    assign start_edge = start_btn     & ~start_prev_q;
    assign blue_edge  = blue_score_up & ~blue_prev_q;
    assign red_edge   = red_score_up  & ~red_prev_q;

    assign blue_inc  = blue_q + SCORE_WIDTH'(blue_edge);
    assign red_inc   = red_q  + SCORE_WIDTH'(red_edge);
    assign blue_wins = blue_edge && (blue_inc == WIN_V);
    assign red_wins  = red_edge  && (red_inc  == WIN_V);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        blue_d   = blue_q;
        red_d    = red_q;
        winner_d = winner_q;

        unique case (state_q)
            ST_IDLE, ST_OVER: begin
                // Restart from OVER behaves exactly like a first start.
                if (start_edge) begin
                    state_d  = ST_SERVE;
                    cnt_d    = SERVE_LOAD;
                    blue_d   = '0;
                    red_d    = '0;
                    winner_d = WIN_NONE;
                end
            end

            ST_SERVE: begin
                if (cnt_q == '0) begin
                    state_d = ST_PLAY;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_PLAY: begin
                if (blue_edge || red_edge) begin
                    blue_d = blue_inc;
                    red_d  = red_inc;
                    if (blue_wins && red_wins) begin
                        state_d  = ST_OVER;
                        winner_d = WIN_DRAW;
                    end else if (blue_wins) begin
                        state_d  = ST_OVER;
                        winner_d = WIN_BLUE;
                    end else if (red_wins) begin
                        state_d  = ST_OVER;
                        winner_d = WIN_RED;
                    end else begin
                        state_d = ST_SERVE;
                        cnt_d   = SERVE_LOAD;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            blue_q       <= '0;
            red_q        <= '0;
            winner_q     <= WIN_NONE;
            start_prev_q <= 1'b1;
            blue_prev_q  <= 1'b1;
            red_prev_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            blue_q       <= blue_d;
            red_q        <= red_d;
            winner_q     <= winner_d;
            start_prev_q <= start_btn;
            blue_prev_q  <= blue_score_up;
            red_prev_q   <= red_score_up;
        end
    end

    assign game_initiated = (state_q == ST_PLAY);
    assign game_over      = (state_q == ST_OVER);
    assign blue_score     = blue_q;
    assign red_score      = red_q;
    assign winner         = winner_q;

endmodule

// File: tb/tb_quidditch_match_controller.sv
// -----------------------------------------------------------------------------
// tb_quidditch_match_controller
//
// Bench for quidditch_match_controller with WIN_SCORE=3, SERVE_DELAY=4.
// Directed match scenarios are followed by a randomized phase; every cycle the
// DUT outputs are compared with a match-rules reference model.
// -----------------------------------------------------------------------------
module tb_quidditch_match_controller;

    localparam int WIN   = 3;
    localparam int SW    = 4;
    localparam int DELAY = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_btn;
    logic          blue_score_up;
    logic          red_score_up;
    logic          game_initiated;
    logic          game_over;
    logic [SW-1:0] blue_score;
    logic [SW-1:0] red_score;
    logic [1:0]    winner;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: match phase as a name, plain integer scores and the
    // number of serve-pause cycles still to elapse.
    string m_phase;
    int    m_blue, m_red, m_winner, m_serve_left;
    bit    m_prev_start, m_prev_blue, m_prev_red;

    quidditch_match_controller #(
        .WIN_SCORE  (WIN),
        .SCORE_WIDTH(SW),
        .SERVE_DELAY(DELAY)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_btn     (start_btn),
        .blue_score_up (blue_score_up),
        .red_score_up  (red_score_up),
        .game_initiated(game_initiated),
        .game_over     (game_over),
        .blue_score    (blue_score),
        .red_score     (red_score),
        .winner        (winner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase      = "IDLE";
        m_blue       = 0;
        m_red        = 0;
        m_winner     = 0;
        m_serve_left = 0;
        m_prev_start = 1'b1;
        m_prev_blue  = 1'b1;
        m_prev_red   = 1'b1;
    endtask

    task automatic begin_serve();
        m_phase      = "SERVE";
        m_serve_left = DELAY;
    endtask

    // Apply the match rules for one clock edge using the inputs present there.
    task automatic model_step();
        bit s_e, b_e, r_e;
        if (rst) begin
            model_reset();
            return;
        end
        s_e = start_btn     && !m_prev_start;
        b_e = blue_score_up && !m_prev_blue;
        r_e = red_score_up  && !m_prev_red;
        m_prev_start = start_btn;
        m_prev_blue  = blue_score_up;
        m_prev_red   = red_score_up;

        if (m_phase == "IDLE" || m_phase == "OVER") begin
            if (s_e) begin
                m_blue   = 0;
                m_red    = 0;
                m_winner = 0;
                begin_serve();
            end
        end else if (m_phase == "SERVE") begin
            m_serve_left--;
            if (m_serve_left == 0) m_phase = "PLAY";
        end else begin
            if (b_e || r_e) begin
                bit bw, rw;
                if (b_e) m_blue++;
                if (r_e) m_red++;
                bw = b_e && (m_blue == WIN);
                rw = r_e && (m_red == WIN);
                if (bw || rw) begin
                    m_phase  = "OVER";
                    m_winner = (bw ? 1 : 0) + (rw ? 2 : 0);
                end else begin
                    begin_serve();
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("game_initiated", 32'(game_initiated), 32'(m_phase == "PLAY"));
        chk("game_over",      32'(game_over),      32'(m_phase == "OVER"));
        chk("blue_score",     32'(blue_score),     32'(m_blue));
        chk("red_score",      32'(red_score),      32'(m_red));
        chk("winner",         32'(winner),         32'(m_winner));
    endtask

    // One goal pulse, then enough cycles for the serve pause to finish.
    task automatic goal(input bit b, input bit r);
        blue_score_up = b;
        red_score_up  = r;
        tick();
        blue_score_up = 1'b0;
        red_score_up  = 1'b0;
        repeat (DELAY + 1) tick();
    endtask

    task automatic press_start();
        start_btn = 1'b0;
        tick();
        start_btn = 1'b1;
        tick();
        start_btn = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gi"},     32'(game_initiated), 32'd0);
        chk({tag, "_go"},     32'(game_over),      32'd0);
        chk({tag, "_blue"},   32'(blue_score),     32'd0);
        chk({tag, "_red"},    32'(red_score),      32'd0);
        chk({tag, "_winner"}, 32'(winner),         32'd0);
    endtask

    initial begin
        model_reset();
        rst           = 1'b1;
        start_btn     = 1'b1;
        blue_score_up = 1'b0;
        red_score_up  = 1'b0;
        repeat (3) tick();

        // Start held high through reset must not start the match.
        rst = 1'b0;
        repeat (3) tick();
        chk_all_zero("idle_after_reset");

        // Start edge, then game_initiated rises exactly DELAY cycles later.
        start_btn = 1'b0;
        tick();
        start_btn = 1'b1;
        tick();
        repeat (DELAY - 1) tick();
        chk("serve_still_low", 32'(game_initiated), 32'd0);
        tick();
        chk("serve_rises", 32'(game_initiated), 32'd1);
        start_btn = 1'b0;

        // Held blue level counts once; serve pause follows.
        blue_score_up = 1'b1;
        repeat (10) tick();
        blue_score_up = 1'b0;
        chk("held_blue_once", 32'(blue_score), 32'd1);
        chk("held_blue_play", 32'(game_initiated), 32'd1);

        // Red goal, then a blue pulse inside the serve pause is ignored.
        red_score_up = 1'b1;
        tick();
        red_score_up  = 1'b0;
        blue_score_up = 1'b1;
        tick();
        blue_score_up = 1'b0;
        repeat (DELAY) tick();
        chk("serve_pulse_blue", 32'(blue_score), 32'd1);
        chk("serve_pulse_red",  32'(red_score),  32'd1);

        // Red to WIN.
        goal(1'b0, 1'b1);
        goal(1'b0, 1'b1);
        chk("red_win_score",  32'(red_score),      32'd3);
        chk("red_win_winner", 32'(winner),         32'd2);
        chk("red_win_go",     32'(game_over),      32'd1);
        chk("red_win_gi",     32'(game_initiated), 32'd0);
        goal(1'b1, 1'b1);
        blue_score_up = 1'b1;
        red_score_up  = 1'b1;
        repeat (5) tick();
        blue_score_up = 1'b0;
        red_score_up  = 1'b0;
        tick();
        chk("over_hold_blue", 32'(blue_score), 32'd1);
        chk("over_hold_red",  32'(red_score),  32'd3);

        // Restart from OVER; start edges in SERVE and PLAY are ignored.
        press_start();
        chk("restart_go",     32'(game_over), 32'd0);
        chk("restart_winner", 32'(winner),    32'd0);
        chk("restart_red",    32'(red_score), 32'd0);
        start_btn = 1'b1;
        tick();
        start_btn = 1'b0;
        repeat (DELAY) tick();
        start_btn = 1'b1;
        tick();
        start_btn = 1'b0;
        tick();
        chk("start_in_play", 32'(game_initiated), 32'd1);

        // 2-2 then simultaneous goals: draw.
        goal(1'b1, 1'b0);
        goal(1'b1, 1'b0);
        goal(1'b0, 1'b1);
        goal(1'b0, 1'b1);
        goal(1'b1, 1'b1);
        chk("draw_winner", 32'(winner),     32'd3);
        chk("draw_blue",   32'(blue_score), 32'd3);
        chk("draw_red",    32'(red_score),  32'd3);

        // 1-2 then simultaneous goals: red wins 2-3.
        press_start();
        repeat (DELAY + 1) tick();
        goal(1'b1, 1'b0);
        goal(1'b0, 1'b1);
        goal(1'b0, 1'b1);
        goal(1'b1, 1'b1);
        chk("sim_winner", 32'(winner),     32'd2);
        chk("sim_blue",   32'(blue_score), 32'd2);
        chk("sim_red",    32'(red_score),  32'd3);

        // Reset mid-serve with the counter at 2.
        press_start();
        tick();
        rst = 1'b1;
        tick();
        chk_all_zero("rst_mid_serve");
        rst = 1'b0;
        tick();

        // Reset mid-play at 2-1.
        press_start();
        repeat (DELAY + 1) tick();
        goal(1'b1, 1'b0);
        goal(1'b1, 1'b0);
        goal(1'b0, 1'b1);
        chk("pre_rst_blue", 32'(blue_score), 32'd2);
        rst = 1'b1;
        tick();
        chk_all_zero("rst_mid_play");
        rst = 1'b0;

        // Randomized phase, checked every cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 7) == 0) start_btn = ~start_btn;
            if ($urandom_range(0, 3) == 0) blue_score_up = ~blue_score_up;
            if ($urandom_range(0, 3) == 0) red_score_up  = ~red_score_up;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
